regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
Write-back scheduler for the core's 2R1W register file. It shares the single write port between two requesters: the in-order pipeline write-back (port A) and the long-latency unit write-back (port B, loads/mul/div). It also keeps a scoreboard of destination registers with long-latency results outstanding, so issue logic can stall on RAW/WAW hazards. It drives the register file write port from registered outputs.

Parameters:
MAX_WAIT, 4, consecutive cycles port B may be refused before it gets priority over A
MAX_OUTSTANDING, 8, maximum simultaneously pending long-latency destinations

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
issue_valid  in  1  instruction issuing this cycle
issue_long  in  1  issuing instruction completes through port B
issue_rd  in  5  destination register of issuing instruction
issue_busy  out  1  combinational: pending[issue_rd]
rs1_addr  in  5  source 1 of instruction in decode
rs2_addr  in  5  source 2 of instruction in decode
rs1_busy  out  1  combinational: pending[rs1_addr]
rs2_busy  out  1  combinational: pending[rs2_addr]
lt_full  out  1  outstanding count == MAX_OUTSTANDING
a_valid  in  1  pipeline write-back request
a_addr  in  5  pipeline destination
a_data  in  32  pipeline result
a_ready  out  1  A accepted this cycle
b_valid  in  1  long-latency write-back request
b_addr  in  5  long-latency destination
b_data  in  32  long-latency result
b_ready  out  1  B accepted this cycle
rf_write_en  out  1  register file write enable (registered)
rf_write_addr  out  5  register file write address (registered)
rf_write_data  out  32  register file write data (registered)

Behaviour:
- Reset (asynchronous, reset_n=0): rf_write_en=0, rf_write_addr=0, rf_write_data=0, pending[31:0]=0, wait_cnt=0, out_cnt=0. Reset mid-operation drops any in-flight grant. No write is issued on the first cycle after release.
- Handshake: a transfer occurs when valid&&ready in the same cycle. ready is combinational from valid and internal state. At most one of a_ready/b_ready is high.
- Arbitration:
  - A wins by default.
  - B wins when !a_valid, or when wait_cnt >= MAX_WAIT.
- Starvation counter wait_cnt: increments, saturating at MAX_WAIT, when b_valid && !b_ready. Clears when B is accepted or b_valid=0.
- Latency: a request accepted at edge N is driven on rf_write_* during cycle N+1 (written into the register file at edge N+2). rf_write_en=0 in any cycle following a cycle with no grant.
- Address x0: accepted normally, but rf_write_en stays 0. x0 is never pending.
- Scoreboard set: pending[issue_rd] sets on issue_valid && issue_long && issue_rd!=0 && !lt_full. out_cnt increments.
- Scoreboard clear: pending[b_addr] clears on B acceptance. out_cnt decrements.
- Set and clear on the same cycle:
  - Same register: set wins; out_cnt unchanged.
  - Different registers: both apply; out_cnt unchanged.
- Issue rules:
  - Issue with lt_full=1 or issue_busy=1 is an upstream protocol error. The scoreboard ignores the set, and a simulation assertion fires.
  - B acceptance for a non-pending address is also an assertion error.
- Read hazard timing: busy bits drop the cycle after B acceptance. The register file's same-cycle write bypass covers the N+1 read.
- out_cnt width: clog2(MAX_OUTSTANDING+1). It never wraps; the assertion guards underflow.

Decomposition:
- Shared core package: REG_ADDR_W=5, XLEN=32, REG_COUNT=32.
- One natural sub-module: wb_port_arbiter (grant logic + wait_cnt). The scoreboard and output registers stay in the top.

Test Plan:
- Reset release, then A writes x5=0xDEADBEEF → a_ready=1 same cycle; next cycle rf_write_en=1, addr=5, data=0xDEADBEEF; following cycle rf_write_en=0.
- A and B both valid continuously, MAX_WAIT=4 → A granted 4 cycles, B granted on the 5th, wait_cnt returns to 0, A resumes.
- Issue long to x7, then rs1_addr=7 → rs1_busy=1 until B writes x7=0x1234; rs1_busy=0 on the next cycle, with rf_write_* carrying x7/0x1234 that cycle.
- Issue long to x0 and A write to x0 → pending unchanged, issue_busy=0, handshake completes, rf_write_en never asserted.
- Issue long to x9 in the same cycle B writes x9 → pending[9] stays 1, out_cnt unchanged; eight issues to distinct registers → lt_full=1, and a ninth issue is ignored with an assertion.
- reset_n asserted between a grant edge and the write cycle → rf_write_en=0 immediately, pending all 0, lt_full=0.

Source files
------------

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared core constants and types for the register-file write-back path.
package regfile_wb_scheduler_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int REG_COUNT  = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic             en;
    reg_addr_t        addr;
    logic [XLEN-1:0]  data;
  } rf_wr_t;

  function automatic logic is_x0(input reg_addr_t a);
    return a == '0;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_wb_port_arbiter.sv
// Write-port arbiter: pipeline (A) wins by default, long-latency (B) wins when
// A is idle or B has been refused MAX_WAIT consecutive cycles.
module wb_port_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_ready,
  output logic b_ready
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_SAT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_q, wait_d;
  logic             b_wins;

  assign b_wins  = !a_valid || (wait_q >= WAIT_SAT);
  assign b_ready = b_valid && b_wins;
  assign a_ready = a_valid && !b_ready;

  always_comb begin
    wait_d = wait_q;
    if (!b_valid || b_ready) begin
      wait_d = '0;
    end else if (wait_q < WAIT_SAT) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between pipeline and long-latency
// write-back, and tracks destinations with long-latency results outstanding.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int MAX_WAIT        = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  issue_valid,
  input  logic                  issue_long,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_busy,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  lt_full,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [XLEN-1:0]       a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [XLEN-1:0]       b_data,
  output logic                  b_ready,
  output logic                  rf_write_en,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [XLEN-1:0]       rf_write_data
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic a_fire, b_fire;

  wb_port_arbiter #(.MAX_WAIT(MAX_WAIT)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .a_ready (a_ready),
    .b_ready (b_ready)
  );

  assign a_fire = a_valid && a_ready;
  assign b_fire = b_valid && b_ready;

  rf_wr_t wr_q, wr_d;

  always_comb begin
    wr_d    = wr_q;
    wr_d.en = 1'b0;
    if (b_fire) begin
      wr_d.en   = !is_x0(b_addr);
      wr_d.addr = b_addr;
      wr_d.data = b_data;
    end else if (a_fire) begin
      wr_d.en   = !is_x0(a_addr);
      wr_d.addr = a_addr;
      wr_d.data = a_data;
    end
  end

  assign rf_write_en   = wr_q.en;
  assign rf_write_addr = wr_q.addr;
  assign rf_write_data = wr_q.data;

  logic [REG_COUNT-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
  logic                 sb_set, sb_clr, clr_same;

  assign issue_busy = pending_q[issue_rd];
  assign rs1_busy   = pending_q[rs1_addr];
  assign rs2_busy   = pending_q[rs2_addr];
  assign lt_full    = out_cnt_q == OUT_MAX;

  // x0 is never pending, so a B write to x0 clears nothing.
  assign sb_clr   = b_fire && pending_q[b_addr];
  assign clr_same = sb_clr && (b_addr == issue_rd);
  // Re-issuing to a register whose result retires this same cycle is legal.
  assign sb_set   = issue_valid && issue_long && !is_x0(issue_rd) && !lt_full
                    && (!issue_busy || clr_same);

  for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_pending
    assign pending_d[gi] = (sb_set && issue_rd == REG_ADDR_W'(gi))
                         || (pending_q[gi] && !(sb_clr && b_addr == REG_ADDR_W'(gi)));
  end

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (sb_set && !sb_clr) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end else if (sb_clr && !sb_set) begin
      out_cnt_d = out_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q      <= '0;
      pending_q <= '0;
      out_cnt_q <= '0;
    end else begin
      wr_q      <= wr_d;
      pending_q <= pending_d;
      out_cnt_q <= out_cnt_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (issue_valid && issue_long && !is_x0(issue_rd)) begin
        assert (!lt_full && (!issue_busy || clr_same))
          else $warning("regfile_wb_scheduler: issue to x%0d dropped (full or busy)", issue_rd);
      end
      if (b_fire && !is_x0(b_addr)) begin
        assert (pending_q[b_addr])
          else $warning("regfile_wb_scheduler: B write to non-pending x%0d", b_addr);
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench: a vector table for the arbitration path, plus hand-written
// sequences for scoreboard, x0 and mid-operation reset corner cases.
module tb_regfile_wb_scheduler;

  logic        clk;
  logic        reset_n;
  logic        issue_valid, issue_long;
  logic [4:0]  issue_rd;
  logic        issue_busy;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy, lt_full;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_scheduler #(.MAX_WAIT(4), .MAX_OUTSTANDING(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .issue_valid   (issue_valid),
    .issue_long    (issue_long),
    .issue_rd      (issue_rd),
    .issue_busy    (issue_busy),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .lt_full       (lt_full),
    .a_valid       (a_valid),
    .a_addr        (a_addr),
    .a_data        (a_data),
    .a_ready       (a_ready),
    .b_valid       (b_valid),
    .b_addr        (b_addr),
    .b_data        (b_data),
    .b_ready       (b_ready),
    .rf_write_en   (rf_write_en),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        iv;
    logic        il;
    logic [4:0]  ird;
    logic [4:0]  r1;
    logic        ar;
    logic        br;
    logic        ib;
    logic        r1b;
    logic        full;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_long = 1'b0; issue_rd = 5'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    a_valid = 1'b0; a_addr = 5'd0; a_data = 32'h0;
    b_valid = 1'b0; b_addr = 5'd0; b_data = 32'h0;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = rd;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            av    aa     ad            bv    ba     bd        iv    il    ird    r1     ar    br    ib    r1b   full  wen   wa     wd
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
    vecs[2] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
    vecs[3] = '{1'b1, 5'd6, 32'h11,       1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 5'd3, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 32'h11};
    vecs[4] = '{1'b1, 5'd6, 32'h12,       1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 5'd3, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 32'h12};
    vecs[5] = '{1'b1, 5'd6, 32'h13,       1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 5'd3, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 32'h13};
    vecs[6] = '{1'b1, 5'd6, 32'h14,       1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 5'd3, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 32'h14};
    vecs[7] = '{1'b1, 5'd6, 32'h15,       1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 5'd3, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'h33};
    vecs[8] = '{1'b1, 5'd6, 32'h15,       1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 32'h15};
    vecs[9] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};

    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wen",  32'(rf_write_en), 32'h0);
    chk("reset_addr", 32'(rf_write_addr), 32'h0);
    chk("reset_data", rf_write_data, 32'h0);
    chk("reset_full", 32'(lt_full), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    edge_settle();
    chk("post_release_wen", 32'(rf_write_en), 32'h0);

    // Table: basic A write, then A/B contention with MAX_WAIT=4
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
      issue_valid = vecs[i].iv; issue_long = vecs[i].il; issue_rd = vecs[i].ird;
      rs1_addr = vecs[i].r1; rs2_addr = 5'd0;
      #1;
      chk($sformatf("v%0d_a_ready", i),    32'(a_ready),    32'(vecs[i].ar));
      chk($sformatf("v%0d_b_ready", i),    32'(b_ready),    32'(vecs[i].br));
      chk($sformatf("v%0d_issue_busy", i), 32'(issue_busy), 32'(vecs[i].ib));
      chk($sformatf("v%0d_rs1_busy", i),   32'(rs1_busy),   32'(vecs[i].r1b));
      chk($sformatf("v%0d_lt_full", i),    32'(lt_full),    32'(vecs[i].full));
      edge_settle();
      chk($sformatf("v%0d_wen", i), 32'(rf_write_en), 32'(vecs[i].wen));
      if (vecs[i].wen) begin
        chk($sformatf("v%0d_waddr", i), 32'(rf_write_addr), 32'(vecs[i].wa));
        chk($sformatf("v%0d_wdata", i), rf_write_data, vecs[i].wd);
      end
      $display("vec %0d: a_ready=%0b b_ready=%0b wen=%0b addr=%0d data=0x%08h",
               i, vecs[i].ar, vecs[i].br, rf_write_en, rf_write_addr, rf_write_data);
    end

    // Long-latency x7: busy until B writes it, drops the cycle after acceptance
    @(negedge clk); idle(); issue(5'd7);
    edge_settle();
    @(negedge clk); idle(); rs1_addr = 5'd7;
    #1 chk("x7_busy_a", 32'(rs1_busy), 32'h1);
    edge_settle();
    @(negedge clk); b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h1234;
    #1;
    chk("x7_b_ready", 32'(b_ready), 32'h1);
    chk("x7_busy_b",  32'(rs1_busy), 32'h1);
    edge_settle();
    chk("x7_busy_drop", 32'(rs1_busy), 32'h0);
    chk("x7_wen",   32'(rf_write_en), 32'h1);
    chk("x7_waddr", 32'(rf_write_addr), 32'h7);
    chk("x7_wdata", rf_write_data, 32'h1234);
    $display("seq x7: busy cleared, write x%0d=0x%08h", rf_write_addr, rf_write_data);

    // x0: accepted, never pending, never written
    @(negedge clk); idle(); issue(5'd0);
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hCAFE;
    #1;
    chk("x0_a_ready",    32'(a_ready), 32'h1);
    chk("x0_issue_busy", 32'(issue_busy), 32'h0);
    edge_settle();
    chk("x0_wen",      32'(rf_write_en), 32'h0);
    chk("x0_rs1_busy", 32'(rs1_busy), 32'h0);
    @(negedge clk); idle();
    edge_settle();
    chk("x0_wen_after", 32'(rf_write_en), 32'h0);
    $display("seq x0: a accepted, rf_write_en=%0b", rf_write_en);

    // Same-cycle set/clear of x9, then fill the scoreboard
    @(negedge clk); idle(); issue(5'd9);
    edge_settle();
    @(negedge clk); idle(); issue(5'd9);
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h99;
    #1;
    chk("x9_b_ready",    32'(b_ready), 32'h1);
    chk("x9_issue_busy", 32'(issue_busy), 32'h1);
    edge_settle();
    rs1_addr = 5'd9;
    #1;
    chk("x9_still_busy", 32'(rs1_busy), 32'h1);
    chk("x9_wen",   32'(rf_write_en), 32'h1);
    chk("x9_waddr", 32'(rf_write_addr), 32'h9);
    $display("seq x9: set/clear same cycle, rs1_busy=%0b", rs1_busy);
    for (int r = 10; r <= 16; r++) begin
      @(negedge clk); idle(); issue(5'(r)); rs2_addr = 5'(r);
      edge_settle();
      chk($sformatf("fill_x%0d_busy", r), 32'(rs2_busy), 32'h1);
      chk($sformatf("fill_x%0d_full", r), 32'(lt_full), (r == 16) ? 32'h1 : 32'h0);
      $display("fill x%0d: lt_full=%0b", r, lt_full);
    end
    @(negedge clk); idle(); issue(5'd17); rs2_addr = 5'd17;
    #1;
    chk("ninth_issue_busy", 32'(issue_busy), 32'h0);
    chk("ninth_full_pre",   32'(lt_full), 32'h1);
    edge_settle();
    chk("ninth_ignored", 32'(rs2_busy), 32'h0);
    chk("ninth_full",    32'(lt_full), 32'h1);
    $display("ninth issue x17: rs2_busy=%0b lt_full=%0b", rs2_busy, lt_full);
    @(negedge clk); idle(); b_valid = 1'b1; b_addr = 5'd10; b_data = 32'hAA;
    #1 chk("drain_b_ready", 32'(b_ready), 32'h1);
    edge_settle();
    chk("drain_full", 32'(lt_full), 32'h0);
    chk("drain_wdata", rf_write_data, 32'hAA);
    $display("drain x10: lt_full=%0b", lt_full);

    // Reset between grant edge and write cycle
    @(negedge clk); idle(); a_valid = 1'b1; a_addr = 5'd8; a_data = 32'h88;
    edge_settle();
    chk("rst_pre_wen", 32'(rf_write_en), 32'h1);
    idle(); rs1_addr = 5'd9; rs2_addr = 5'd16;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_wen",   32'(rf_write_en), 32'h0);
    chk("rst_addr",  32'(rf_write_addr), 32'h0);
    chk("rst_data",  rf_write_data, 32'h0);
    chk("rst_full",  32'(lt_full), 32'h0);
    chk("rst_rs1",   32'(rs1_busy), 32'h0);
    chk("rst_rs2",   32'(rs2_busy), 32'h0);
    @(negedge clk); reset_n = 1'b1;
    edge_settle();
    chk("rst_release_wen", 32'(rf_write_en), 32'h0);
    $display("mid-op reset: rf_write_en=%0b lt_full=%0b", rf_write_en, lt_full);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
